mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-to-1 single-bit multiplexer among four requesters. It accepts per-requester request lines and data bits and grants exactly one requester at a time, for a bounded number of cycles. It drives the multiplexer select pair A/B from the registered grant. It sits between the requesting logic and the `mux_4_to_1_dataflow` datapath, which it instantiates.

---
 rtl/mux_arb_pkg.sv | 27 ++
 rtl/mux_4_to_1_dataflow.sv | 11 +
 rtl/mux_rr_arbiter.sv | 103 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds requester count, select width, FSM states and the rotating priority search.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // First requester found scanning last+1, last+2, last+3, last (mod 4);
    // the caller only uses the result when at least one request is set.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] last
    );
        logic [SEL_W-1:0] idx;
        rr_pick = last;
        for (int k = N_REQ - 1; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux_4_to_1_dataflow.sv
// Single-bit 4-to-1 multiplexer in dataflow style; {A,B} selects I[{A,B}].
module mux_4_to_1_dataflow (
    input  logic [3:0] I,
    input  logic       A,
    input  logic       B,
    output logic       Y
);

    assign Y = I[{A, B}];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 mux among four requesters, with a
// bounded hold time per grant and back-to-back handoff.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] I,
    output logic [N_REQ-1:0] gnt,
    output logic             A,
    output logic             B,
    output logic             Y,
    output logic             valid
);

    localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic             rel;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    owner_d = rr_pick(req, last_q);
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                rel = !req[owner_q] || (cnt_q == CNT_LAST);
                if (rel) begin
                    // Old owner becomes lowest priority for this handoff.
                    last_d = owner_q;
                    cnt_d  = '0;
                    if (|req) begin
                        owner_d = rr_pick(req, owner_q);
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase

        gnt_d = '0;
        if (state_d == GRANT) gnt_d[owner_d] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign A     = owner_q[1];
    assign B     = owner_q[0];
    assign valid = |gnt_q;

    mux_4_to_1_dataflow u_mux (
        .I (I),
        .A (A),
        .B (B),
        .Y (Y)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus a randomized
// phase, all compared against a tenure/owner reference model.
module tb_mux_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] I;
    logic [3:0] gnt;
    logic       A, B, Y, valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner index (-1 when idle), cycles held so far, last owner.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 3;

    mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .I       (I),
        .gnt     (gnt),
        .A       (A),
        .B       (B),
        .Y       (Y),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    function automatic int search(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (!reset_n) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = 3;
        end else if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner = search(req, m_last);
                m_cnt   = 0;
            end
        end else if (!req[m_owner] || m_cnt == HOLD - 1) begin
            m_last  = m_owner;
            m_owner = search(req, m_last);
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        logic [3:0] exp_gnt;
        int         sel;
        exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        sel     = (m_owner < 0) ? 0 : m_owner;
        check("gnt",   gnt,          exp_gnt);
        check("A",     {3'b000, A},  {3'b000, 1'(sel >> 1)});
        check("B",     {3'b000, B},  {3'b000, 1'(sel & 1)});
        check("valid", {3'b000, valid}, {3'b000, 1'(m_owner >= 0)});
        check("Y",     {3'b000, Y},  {3'b000, I[sel]});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_i(input logic [3:0] v);
        I = v;
        #1;
        check("Y_comb", {3'b000, Y}, {3'b000, I[(m_owner < 0) ? 0 : m_owner]});
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b1111;
        I       = 4'b0000;

        // Reset held two cycles with all requesting.
        tick();
        tick();
        check("rst_gnt", gnt, 4'b0000);

        // Release: requester 0 first, then full contention rotates every HOLD cycles.
        reset_n = 1'b1;
        tick();
        check("rst_rel", gnt, 4'b0001);
        for (int c = 0; c < 4 * HOLD + 2; c++) tick();

        // Idle, then single holder with I sweep.
        req = 4'b0000;
        tick();
        tick();
        check("idle", gnt, 4'b0000);
        req = 4'b0100;
        for (int v = 0; v < 16; v++) begin
            set_i(4'(v));
            tick();
        end
        check("single", gnt, 4'b0100);

        // Early release: owner 1 drops while requester 3 waits.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req = 4'b0010;
        tick();
        check("er_own1", gnt, 4'b0010);
        req = 4'b1010;
        tick();
        req = 4'b1000;
        tick();
        check("er_hand", gnt, 4'b1000);
        req = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("er_hold", gnt, 4'b1000);
        end
        tick();
        check("er_next", gnt, 4'b0010);

        // Reset mid-grant: owner 2 with cnt 2, then pointer restarts at 0.
        reset_n = 1'b0;
        req = 4'b1111;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 11; c++) tick();
        check("mid_own2", gnt, 4'b0100);
        reset_n = 1'b0;
        tick();
        check("mid_rst", gnt, 4'b0000);
        reset_n = 1'b1;
        tick();
        check("mid_rel", gnt, 4'b0001);

        // Datapath sweep for each forced owner.
        for (int k = 0; k < 4; k++) begin
            req = 4'b0000;
            tick();
            req = 4'b0001 << k;
            for (int v = 0; v < 16; v++) begin
                set_i(4'(v));
                tick();
            end
        end

        // Randomized traffic with sticky requests and occasional resets.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            reset_n = ($urandom_range(0, 49) != 0);
            set_i(4'($urandom_range(0, 15)));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
